// File: rtl/data_sram_slave_if.sv
// Data-side SRAM-like request/response bus.
// Signals:
//   req/wr/size/addr/wstrb/wdata  master -> slave  request channel
//   addr_ok                       slave -> master  request accepted when req & addr_ok
//   data_ok/rdata                 slave -> master  in-order response, one cycle each
//   pending                       slave -> master  accepted requests not yet answered
// MAX_OUT must match the slave's MAX_OUT so that pending has the right width.
interface data_sram_slave_if #(
    parameter int MAX_OUT = 4
);
    localparam int PEND_W = $clog2(MAX_OUT) + 1;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [31:0]       addr;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;
    logic [PEND_W-1:0] pending;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata, pending
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata, pending
    );
endinterface

// File: rtl/data_sram_slave.sv
// Responder for the data-side SRAM-like bus. Requests are performed on an
// internal word-addressed memory when accepted; responses come back in order
// from a circular queue after a fixed LATENCY.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-high; flushes the response queue, keeps memory
//   bus    data_sram_slave_if.slave (request, response and pending count)
// Parameters:
//   IDX_WIDTH  word-index bits (2^IDX_WIDTH 32-bit words)
//   LATENCY    cycles from accept to data_ok, >= 1
//   MAX_OUT    outstanding request limit, power of two, >= 2
module data_sram_slave #(
    parameter int IDX_WIDTH = 10,
    parameter int LATENCY   = 2,
    parameter int MAX_OUT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    data_sram_slave_if.slave  bus
);
    localparam int PTR_W  = $clog2(MAX_OUT);
    localparam int PEND_W = PTR_W + 1;
    localparam int CD_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CD_W-1:0]   CD_INIT   = CD_W'(LATENCY - 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(MAX_OUT);

    logic [31:0] mem [2**IDX_WIDTH];

    logic [MAX_OUT-1:0] q_valid_reg;
    logic [MAX_OUT-1:0] q_valid_next;
    logic [MAX_OUT-1:0] q_write_reg;
    logic [31:0]        q_rdata_reg [MAX_OUT];
    logic [CD_W-1:0]    q_cd_reg    [MAX_OUT];
    logic [CD_W-1:0]    q_cd_next   [MAX_OUT];

    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PEND_W-1:0]  pending_reg;

    logic [IDX_WIDTH-1:0] idx;
    logic                 addr_ok;
    logic                 accept;
    logic                 pop;
    logic [3:0]           lane_we;
    logic                 unused_bits;

    // Upper address bits alias; size is informational only.
    assign idx         = bus.addr[IDX_WIDTH+1:2];
    assign unused_bits = ^{bus.size, bus.addr[31:IDX_WIDTH+2], bus.addr[1:0]};

    // addr_ok depends only on registered state, so a same-cycle pop never
    // opens a slot while full.
    assign addr_ok = (pending_reg != PEND_FULL);
    assign accept  = bus.req & addr_ok & ~reset;
    assign pop     = q_valid_reg[rd_ptr_reg] & (q_cd_reg[rd_ptr_reg] == '0);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = accept & bus.wr & bus.wstrb[gi];
        end
    endgenerate

    // Read-first memory: the captured read word is the content before this
    // edge's write. Queue payload needs no reset; validity is tracked apart.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
                mem[idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end
        if (accept) begin
            q_rdata_reg[wr_ptr_reg] <= mem[idx];
            q_write_reg[wr_ptr_reg] <= bus.wr;
        end
    end

    // Per-entry next state: push loads the countdown, every valid entry
    // counts down to zero, and the head clears when it is returned.
    generate
        for (genvar gi = 0; gi < MAX_OUT; gi++) begin : g_entry
            logic push_here;
            logic pop_here;
            assign push_here = accept & (wr_ptr_reg == PTR_W'(gi));
            assign pop_here  = pop & (rd_ptr_reg == PTR_W'(gi));

            assign q_valid_next[gi] = push_here ? 1'b1 :
                                      pop_here  ? 1'b0 : q_valid_reg[gi];
            assign q_cd_next[gi]    = push_here ? CD_INIT :
                                      (q_valid_reg[gi] && q_cd_reg[gi] != '0) ?
                                      q_cd_reg[gi] - 1'b1 : q_cd_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        q_cd_reg <= q_cd_next;
        if (reset) begin
            q_valid_reg <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            pending_reg <= '0;
        end else begin
            q_valid_reg <= q_valid_next;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({accept, pop})
                2'b10:   pending_reg <= pending_reg + 1'b1;
                2'b01:   pending_reg <= pending_reg - 1'b1;
                default: pending_reg <= pending_reg;
            endcase
        end
    end

    assign bus.addr_ok = addr_ok;
    assign bus.data_ok = pop;
    assign bus.rdata   = (pop && !q_write_reg[rd_ptr_reg]) ? q_rdata_reg[rd_ptr_reg] : '0;
    assign bus.pending = pending_reg;
endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: instance A (LATENCY 2) and instance B
// (LATENCY 6), both MAX_OUT 4. Each accept pushes the expected response
// and its due cycle into a queue; one monitor per instance pops and compares.
module tb_data_sram_slave;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   txn_id = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        int          due;
        int          id;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    data_sram_slave_if #(.MAX_OUT(4)) ia ();
    data_sram_slave_if #(.MAX_OUT(4)) ib ();

    data_sram_slave #(.IDX_WIDTH(10), .LATENCY(2), .MAX_OUT(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    data_sram_slave #(.IDX_WIDTH(10), .LATENCY(6), .MAX_OUT(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    // Monitors: queues are discarded while reset is high.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            qa.delete();
        end else if (ia.data_ok) begin
            checks++;
            if (qa.size() == 0) begin
                failures++;
                $display("FAIL a_spurious: data_ok at cycle %0d rdata=%h, required no response", cyc, ia.rdata);
            end else begin
                e = qa.pop_front();
                if (ia.rdata !== e.rdata || cyc != e.due) begin
                    failures++;
                    $display("FAIL a_resp #%0d: got rdata=%h cycle=%0d, required rdata=%h cycle=%0d",
                             e.id, ia.rdata, cyc, e.rdata, e.due);
                end else begin
                    $display("resp a #%0d cycle=%0d rdata=%h ok", e.id, cyc, ia.rdata);
                end
            end
        end else if (ia.rdata !== 32'h0) begin
            checks++;
            failures++;
            $display("FAIL a_idle_rdata: got %h at cycle %0d, required 0", ia.rdata, cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            qb.delete();
        end else if (ib.data_ok) begin
            checks++;
            if (qb.size() == 0) begin
                failures++;
                $display("FAIL b_spurious: data_ok at cycle %0d rdata=%h, required no response", cyc, ib.rdata);
            end else begin
                e = qb.pop_front();
                if (ib.rdata !== e.rdata || cyc != e.due) begin
                    failures++;
                    $display("FAIL b_resp #%0d: got rdata=%h cycle=%0d, required rdata=%h cycle=%0d",
                             e.id, ib.rdata, cyc, e.rdata, e.due);
                end else begin
                    $display("resp b #%0d cycle=%0d rdata=%h ok", e.id, cyc, ib.rdata);
                end
            end
        end else if (ib.rdata !== 32'h0) begin
            checks++;
            failures++;
            $display("FAIL b_idle_rdata: got %h at cycle %0d, required 0", ib.rdata, cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end else begin
            $display("check %s ok: %h", nm, got);
        end
    endtask

    // Presents one request (req stays high on return so consecutive calls
    // are back-to-back) and records the expected response on acceptance.
    task automatic issue(input int sel, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d,
                         input logic [31:0] exp, output int acc);
        bit   done = 0;
        exp_t e;
        acc = -1;
        txn_id++;
        if (sel == 0) begin
            ia.req = 1'b1; ia.wr = w; ia.addr = a; ia.wstrb = s; ia.wdata = d; ia.size = 2'd2;
        end else begin
            ib.req = 1'b1; ib.wr = w; ib.addr = a; ib.wstrb = s; ib.wdata = d; ib.size = 2'd2;
        end
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if ((sel == 0) ? ia.addr_ok : ib.addr_ok) begin
                done = 1;
                acc = cyc;
                e.rdata = w ? 32'h0 : exp;
                e.id = txn_id;
                if (sel == 0) begin
                    e.due = cyc + 2;
                    qa.push_back(e);
                end else begin
                    e.due = cyc + 6;
                    qb.push_back(e);
                end
                $display("req %s #%0d cycle=%0d %s addr=%h wstrb=%h wdata=%h",
                         (sel == 0) ? "a" : "b", txn_id, cyc, w ? "wr" : "rd", a, s, d);
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout #%0d: got no addr_ok, required acceptance", txn_id);
        end
    endtask

    task automatic idle(input int n);
        ia.req = 1'b0;
        ib.req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int sel, input string nm);
        int k = 0;
        ia.req = 1'b0;
        ib.req = 1'b0;
        while (((sel == 0) ? qa.size() : qb.size()) != 0 && k < 80) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 80) begin
            checks++;
            failures++;
            $display("FAIL %s_drain: responses still outstanding, required none", nm);
        end
        @(negedge clk);
        chk({nm, "_pending"}, 32'((sel == 0) ? ia.pending : ib.pending), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int c0;
        ia.req = 0; ia.wr = 0; ia.size = 0; ia.addr = 0; ia.wstrb = 0; ia.wdata = 0;
        ib.req = 0; ib.wr = 0; ib.size = 0; ib.addr = 0; ib.wstrb = 0; ib.wdata = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_addr_ok", 32'(ia.addr_ok), 32'd1);
        chk("rst_data_ok", 32'(ia.data_ok), 32'd0);
        chk("rst_rdata", ia.rdata, 32'h0);
        chk("rst_pending", 32'(ia.pending), 32'd0);
        chk("rst_b_addr_ok", 32'(ib.addr_ok), 32'd1);
        @(posedge clk);
        #1;

        // Basic write then read, back-to-back.
        issue(0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, acc);
        issue(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, acc);
        // Byte-lane merge.
        issue(0, 1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0, acc);
        issue(0, 1'b1, 32'h0000_0020, 4'b0100, 32'h00AB_0000, 32'h0, acc);
        issue(0, 1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'h11AB_3344, acc);
        // Aliasing: 0x1000 and 0x0000 share a word; read directly follows write.
        issue(0, 1'b1, 32'h0000_1000, 4'hF, 32'h5555_5555, 32'h0, acc);
        issue(0, 1'b0, 32'h0000_0000, 4'h0, 32'h0, 32'h5555_5555, acc);
        issue(0, 1'b0, 32'hF000_2000, 4'h0, 32'h0, 32'h5555_5555, acc);
        drain(0, "basic");

        // Eight back-to-back reads at LATENCY 2.
        for (int i = 0; i < 8; i++)
            issue(0, 1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hA5A5_0000 + 32'(i), 32'h0, acc);
        for (int i = 0; i < 8; i++)
            issue(0, 1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0, 32'hA5A5_0000 + 32'(i), acc);
        drain(0, "b2b");

        // Pointer wrap: 20 write/read pairs with req held high throughout.
        for (int i = 0; i < 20; i++) begin
            issue(0, 1'b1, 32'h200 + 32'(8 * i), 4'hF, 32'h1000_0000 + 32'(i * 32'h0011_0001), 32'h0, acc);
            issue(0, 1'b0, 32'h200 + 32'(8 * i), 4'h0, 32'h0, 32'h1000_0000 + 32'(i * 32'h0011_0001), acc);
        end
        drain(0, "wrap");

        // Instance B: preload 0x40, then fill the queue at LATENCY 6.
        issue(1, 1'b1, 32'h0000_0040, 4'hF, 32'hCAFE_F00D, 32'h0, acc);
        drain(1, "b_preload");
        issue(1, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'hCAFE_F00D, c0);
        for (int i = 1; i < 4; i++)
            issue(1, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'hCAFE_F00D, acc);
        ib.req = 1'b0;
        @(negedge clk);
        chk("full_pending", 32'(ib.pending), 32'd4);
        for (int k = 4; k <= 7; k++) begin
            if (k > 4) begin
                @(posedge clk);
                #1;
                @(negedge clk);
            end
            chk($sformatf("full_addr_ok_t%0d", k), 32'(ib.addr_ok), (k == 7) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        drain(1, "full");

        // Reset with three reads outstanding; a write in the reset cycle is dropped.
        for (int i = 0; i < 3; i++)
            issue(1, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'hCAFE_F00D, acc);
        reset = 1'b1;
        ib.wr = 1'b1; ib.wstrb = 4'hF; ib.wdata = 32'h1234_5678; ib.addr = 32'h0000_0040;
        @(negedge clk);
        chk("pre_reset_pending", 32'(ib.pending), 32'd3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ib.req = 1'b0;
        @(negedge clk);
        chk("post_reset_pending", 32'(ib.pending), 32'd0);
        chk("post_reset_addr_ok", 32'(ib.addr_ok), 32'd1);
        @(posedge clk);
        #1;
        idle(10);
        issue(1, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'hCAFE_F00D, acc);
        drain(1, "reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_sram_slave.md
# data_sram_slave

Responder end of the data-side SRAM-like interface: accepts requests from the LSU/MEM path (`req`/`addr_ok`), performs them on an internal word-addressed memory, and returns in-order responses (`data_ok`/`rdata`) after a fixed, parameterized latency. It replaces the ideal SRAM in simulation and on FPGA. It exercises the pipeline's stall path (`MEM_ready_go` waiting on `data_ok`) with multiple outstanding accesses.

## Interface
- `IDX_WIDTH`, default 10: word-index bits; the memory holds 2^IDX_WIDTH 32-bit words.
- `LATENCY`, default 2: cycles from acceptance to `data_ok`; must be ≥1.
- `MAX_OUT`, default 4: maximum outstanding requests; must be a power of 2, ≥2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  request valid.
- `wr`  in  1  1 = write, 0 = read.
- `size`  in  2  0 = byte, 1 = half, 2 = word. Informational only; `wstrb` governs writes.
- `addr`  in  32  byte address; word index = `addr[IDX_WIDTH+1:2]`.
- `wstrb`  in  4  byte enables for writes; ignored for reads.
- `wdata`  in  32  write data, already lane-aligned by the master.
- `addr_ok`  out  1  request accepted this cycle when `req & addr_ok`.
- `data_ok`  out  1  response valid, one cycle per request.
- `rdata`  out  32  full word for read responses; 0 for write responses and when `data_ok` = 0.
- `pending`  out  $clog2(MAX_OUT)+1  number of accepted requests not yet responded to.

## Operation
- **Acceptance:** `addr_ok = (pending != MAX_OUT)`.
  - Depends only on registered state; no combinational path from `req` or from the pop in the same cycle.
  - When full, `addr_ok` stays 0 even in a cycle where `data_ok` pops an entry.
- **Write on accept:** the memory is updated at the accepting edge, per byte lane where `wstrb[i]` = 1. Upper `addr` bits above the index alias.
- **Read on accept:** the word is captured into the response entry at the accepting edge, using the memory contents *before* this edge's write.
  - Since only one request is accepted per cycle, a read issued after a write to the same word returns the new data.
- **Response queue:** circular FIFO of `MAX_OUT` entries, each holding {`rdata`, `is_write`, `countdown`}.
  - Push on accept with `countdown = LATENCY-1`.
  - Every cycle, every valid entry's `countdown` decrements, saturating at 0.
- **Response:** `data_ok = head_valid & (head.countdown == 0)`.
  - The head pops at that edge; the master must consume it, as there is no back-pressure.
  - `rdata` = `head.rdata` for reads, 0 for writes.
- **Ordering:** responses are strictly in acceptance order, at most one per cycle.
- **Pointers and count:**
  - Read and write pointers are `$clog2(MAX_OUT)` bits, wrapping modulo `MAX_OUT`.
  - `pending` increments on accept and decrements on pop; it is unchanged when both happen in the same cycle.
- **`size`:** not checked. A `wstrb` inconsistent with `size` is the master's error.

## Timing
- **Reset values:** `addr_ok` = 1 from the first cycle after reset; `data_ok` = 0, `rdata` = 0, `pending` = 0; pointers 0, all entries invalid.
  - Memory contents are not reset.
- **Latency:** a request accepted in cycle T gives `data_ok` in cycle T+`LATENCY`, when the pipe is unblocked.
  - Back-to-back accepts in T, T+1, … give `data_ok` in T+L, T+L+1, …
  - The sustained rate is 1 request/cycle when `MAX_OUT ≥ LATENCY+1`. Otherwise `addr_ok` throttles.
- **Full:** when `pending == MAX_OUT`, `addr_ok` = 0.
  - It returns to 1 in the cycle after the pop edge.
- **Empty:** `data_ok` = 0. A request may be accepted in the same cycle.
- **Reset mid-operation:**
  - All queued responses are discarded and no `data_ok` follows.
  - Writes already accepted remain in memory.
  - A request presented in the reset cycle is not accepted and does not modify memory.

## Test plan
1. **Basic write then read.** After reset, with `LATENCY` = 2:
   - Write addr `0x0000_0010`, `wstrb` `4'hF`, data `0xDEADBEEF` accepted at cycle 1 → `data_ok` at cycle 3 with `rdata` 0.
   - Read of the same addr accepted at cycle 2 → `data_ok` at cycle 4 with `rdata` `0xDEADBEEF`.
2. **Byte-lane merge.** Word `0x11223344` at addr `0x20`, then write `wstrb` `4'b0100`, `wdata` `0x00AB0000` → a subsequent read returns `0x11AB3344`.
3. **Back-to-back reads and full stall.** 8 consecutive reads with `MAX_OUT` = 4, `LATENCY` = 2 → 1 accept/cycle, `data_ok` in order, 2 cycles after each accept. Then with `LATENCY` = 6:
   - `addr_ok` drops after the 4th accept and `pending` = 4.
   - `addr_ok` rises in the cycle after the first `data_ok`.
4. **Pointer wrap.** 20 alternating write/read pairs at distinct addresses, with `req` held continuously → every read returns its paired write data, with no response lost or duplicated. `pending` returns to 0.
5. **Reset mid-flight.** Reset asserted with 3 pending reads:
   - No `data_ok` appears afterwards; `pending` = 0 and `addr_ok` = 1 after reset.
   - A previously accepted write to `0x40` (value `0xCAFEF00D`) reads back intact.
6. **Aliasing and the same-cycle rule, with `IDX_WIDTH` = 10.**
   - Write `0x5555_5555` to addr `0x1000` → a read of addr `0x0000` returns `0x5555_5555`.
   - A read issued in the cycle directly after a write to the same word returns the written data.
